// File: rtl/alu181_nslice.sv
// Multi-cycle WIDTH-bit 74181-function ALU: one 4-bit slice per clock, LSB first,
// with three registered ripple carries (cin, as-if-0, as-if-1) and a start/busy/done handshake.
module alu181_nslice #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             g,
    output logic             p,
    output logic             a_eq_b
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic [2:0]       c_q, c_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             cout_q, cout_d, g_q, g_d, p_q, p_d, eq_q, eq_d;

    logic [3:0]       a_n, b_n, x_n, y_n, nib;
    logic [2:0]       carry_nx;
    logic [WIDTH-1:0] shadow_nx;

    // Ripple carry through one nibble of X+Y with generate = x&y, propagate = x^y.
    function automatic logic carry4(input logic [3:0] x, input logic [3:0] y, input logic c_in);
        logic c;
        c = c_in;
        for (int i = 0; i < 4; i++) begin
            c = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
        end
        return c;
    endfunction

    // Current slice: 74181 select decode into X and Y, then sum or logic result.
    always_comb begin
        a_n = a_q[3:0];
        b_n = b_q[3:0];
        x_n = a_n | (b_n & {4{s_q[0]}}) | (~b_n & {4{s_q[1]}});
        y_n = (a_n & ~b_n & {4{s_q[2]}}) | (a_n & b_n & {4{s_q[3]}});
        nib = m_q ? ~(x_n ^ y_n) : (x_n + y_n + 4'(c_q[0]));
        carry_nx = m_q ? 3'b000
                       : {carry4(x_n, y_n, c_q[2]), carry4(x_n, y_n, c_q[1]), carry4(x_n, y_n, c_q[0])};
        shadow_nx = (WIDTH'(nib) << (WIDTH - 4)) | (shadow_q >> 4);
    end

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        c_d      = c_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        f_d      = f_q;
        cout_d   = cout_q;
        g_d      = g_q;
        p_d      = p_q;
        eq_d     = eq_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    s_d      = s;
                    m_d      = m;
                    c_d      = m ? 3'b000 : {1'b1, 1'b0, cin};
                    idx_d    = '0;
                    shadow_d = '0;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> 4;
                b_d      = b_q >> 4;
                shadow_d = shadow_nx;
                c_d      = carry_nx;
                idx_d    = idx_q + IW'(1);
                if (idx_q == IW'(NSLICE - 1)) begin
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    f_d     = shadow_nx;
                    cout_d  = carry_nx[0];
                    g_d     = carry_nx[1];
                    p_d     = carry_nx[2];
                    eq_d    = &shadow_nx;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            c_q      <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            f_q      <= '0;
            cout_q   <= 1'b0;
            g_q      <= 1'b0;
            p_q      <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            c_q      <= c_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            f_q      <= f_d;
            cout_q   <= cout_d;
            g_q      <= g_d;
            p_q      <= p_d;
            eq_q     <= eq_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign f      = f_q;
    assign cout   = cout_q;
    assign g      = g_q;
    assign p      = p_q;
    assign a_eq_b = eq_q;

endmodule

// File: tb/tb_alu181_nslice.sv
// Bench for alu181_nslice (WIDTH=16): directed cases plus random operations checked
// against a table-driven word-level model of the 32 functions.
module tb_alu181_nslice;

    localparam int unsigned W = 16;

    logic         clk, rst, start, m, cin;
    logic [W-1:0] a, b;
    logic [3:0]   s;
    logic         busy, done, cout, g, p, a_eq_b;
    logic [W-1:0] f;

    int total = 0;
    int bad   = 0;

    alu181_nslice #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cin(cin),
        .busy(busy), .done(done), .f(f), .cout(cout), .g(g), .p(p), .a_eq_b(a_eq_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {p, g, cout, f}, word-level straight from the function tables.
    function automatic logic [W+2:0] model(input logic [W-1:0] ma, mb, input logic [3:0] ms,
                                           input logic mm, mc);
        logic [W:0]   x, y, sc, s0, s1, ea, eb, ones;
        logic [W-1:0] lf;
        if (mm) begin
            case (ms)
                4'd0:  lf = ~ma;
                4'd1:  lf = ~(ma | mb);
                4'd2:  lf = ~ma & mb;
                4'd3:  lf = '0;
                4'd4:  lf = ~(ma & mb);
                4'd5:  lf = ~mb;
                4'd6:  lf = ma ^ mb;
                4'd7:  lf = ma & ~mb;
                4'd8:  lf = ~ma | mb;
                4'd9:  lf = ~(ma ^ mb);
                4'd10: lf = mb;
                4'd11: lf = ma & mb;
                4'd12: lf = '1;
                4'd13: lf = ma | ~mb;
                4'd14: lf = ma | mb;
                default: lf = ma;
            endcase
            return {3'b000, lf};
        end
        ea   = {1'b0, ma};
        eb   = {1'b0, mb};
        ones = {1'b0, {W{1'b1}}};
        case (ms)
            4'd0:  begin x = ea;                y = '0;                end
            4'd1:  begin x = {1'b0, ma | mb};   y = '0;                end
            4'd2:  begin x = {1'b0, ma | ~mb};  y = '0;                end
            4'd3:  begin x = ones;              y = '0;                end
            4'd4:  begin x = ea;                y = {1'b0, ma & ~mb};  end
            4'd5:  begin x = {1'b0, ma | mb};   y = {1'b0, ma & ~mb};  end
            4'd6:  begin x = ea;                y = {1'b0, ~mb};       end
            4'd7:  begin x = ones;              y = {1'b0, ma & ~mb};  end
            4'd8:  begin x = ea;                y = {1'b0, ma & mb};   end
            4'd9:  begin x = ea;                y = eb;                end
            4'd10: begin x = {1'b0, ma | ~mb};  y = {1'b0, ma & mb};   end
            4'd11: begin x = ones;              y = {1'b0, ma & mb};   end
            4'd12: begin x = ea;                y = ea;                end
            4'd13: begin x = {1'b0, ma | mb};   y = ea;                end
            4'd14: begin x = {1'b0, ma | ~mb};  y = ea;                end
            default: begin x = ones;            y = ea;                end
        endcase
        sc = x + y + (W+1)'(mc);
        s0 = x + y;
        s1 = x + y + (W+1)'(1);
        return {s1[W], s0[W], sc[W], sc[W-1:0]};
    endfunction

    // Issue one request and wait (bounded) for done; optionally disturb inputs while busy.
    task automatic launch(input logic [W-1:0] ta, tb_, input logic [3:0] ts, input logic tm, tc,
                          input bit scramble, output int nb, output bit seen);
        int n;
        a = ta; b = tb_; s = ts; m = tm; cin = tc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nb = 0;
        n  = 0;
        while (!done && n < 40) begin
            if (busy) nb++;
            if (scramble) begin
                a = W'($urandom); b = W'($urandom); s = 4'($urandom);
                m = 1'($urandom); cin = 1'($urandom); start = 1'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        seen = done;
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] ta, tb_, input logic [3:0] ts,
                             input logic tm, tc, input int nb, input bit seen);
        logic [W+2:0] e;
        e = model(ta, tb_, ts, tm, tc);
        chk({tag, "_done"}, 32'(seen), 32'd1);
        chk({tag, "_busy"}, 32'(nb), 32'd4);
        chk({tag, "_f"}, 32'(f), 32'(e[W-1:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(e[W]));
        chk({tag, "_g"}, 32'(g), 32'(e[W+1]));
        chk({tag, "_p"}, 32'(p), 32'(e[W+2]));
        chk({tag, "_eq"}, 32'(a_eq_b), 32'(&e[W-1:0]));
        chk({tag, "_inv"}, 32'(cout), 32'(g | (p & (tc & ~tm))));
    endtask

    task automatic op(input string tag, input logic [W-1:0] ta, tb_, input logic [3:0] ts,
                      input logic tm, tc, input bit scramble);
        int nb;
        bit seen;
        launch(ta, tb_, ts, tm, tc, scramble, nb, seen);
        check_res(tag, ta, tb_, ts, tm, tc, nb, seen);
    endtask

    initial begin
        int nb, n;
        bit seen, got_done;
        logic [W-1:0] held;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_flags", {28'd0, cout, g, p, a_eq_b}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        op("add", 16'h1234, 16'h0FCD, 4'd9, 1'b0, 1'b0, 1'b0);
        chk("add_const", 32'(f), 32'h2201);
        op("cmp0", 16'h5A5A, 16'h5A5A, 4'd6, 1'b0, 1'b0, 1'b0);
        chk("cmp0_const", {15'd0, a_eq_b, f}, {15'd0, 1'b1, 16'hFFFF});
        op("cmp1", 16'h5A5A, 16'h5A5A, 4'd6, 1'b0, 1'b1, 1'b0);
        chk("cmp1_const", {15'd0, cout, f}, {15'd0, 1'b1, 16'h0000});
        op("ripple", 16'hFFFF, 16'h0000, 4'd9, 1'b0, 1'b1, 1'b0);
        chk("ripple_const", {13'd0, cout, g, p, f}, {13'd0, 3'b101, 16'h0000});
        op("xor", 16'hF0F0, 16'hFF00, 4'd6, 1'b1, 1'b1, 1'b0);
        chk("xor_const", {13'd0, cout, g, p, f}, {13'd0, 3'b000, 16'h0FF0});

        // Results hold after done, and done is a single-cycle pulse.
        held = f;
        @(posedge clk); #1;
        chk("done_pulse", 32'(done), 32'd0);
        @(posedge clk); #1;
        chk("hold_f", 32'(f), 32'(held));

        // Inputs and start toggled during busy must not disturb the accepted request.
        op("ign", 16'hBEEF, 16'h1357, 4'd5, 1'b0, 1'b1, 1'b1);

        // Start in the done cycle is accepted.
        launch(16'h8001, 16'h7FFF, 4'd9, 1'b0, 1'b0, 1'b0, nb, seen);
        check_res("b2b_a", 16'h8001, 16'h7FFF, 4'd9, 1'b0, 1'b0, nb, seen);
        a = 16'h00F0; b = 16'h0F0F; s = 4'd14; m = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_done_fall", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        nb = 1; n = 0;
        @(posedge clk); #1;
        while (!done && n < 40) begin
            if (busy) nb++;
            @(posedge clk); #1;
            n++;
        end
        check_res("b2b_b", 16'h00F0, 16'h0F0F, 4'd14, 1'b1, 1'b0, nb, 1'(done));

        // Reset mid-operation aborts with no done pulse.
        a = 16'h4321; b = 16'h1111; s = 4'd9; m = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_f", 32'(f), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        got_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) got_done = 1'b1;
        end
        chk("mid_no_done", 32'(got_done), 32'd0);
        op("after_rst", 16'h4321, 16'h1111, 4'd9, 1'b0, 1'b0, 1'b0);

        // Random sweep over all modes and selects.
        for (int i = 0; i < 200; i++) begin
            op("rnd", W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
               bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
